irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt receiver that sits between the SoC's interrupt sources (the timer interrupt line as source 1, plus up to NSRC-1 further peripheral lines) and the CPU core. It latches incoming requests, gates them through per-source enable bits and arbitrates by fixed priority. The CPU gets a single irq_out line and a memory-mapped claim/complete register window on the SoC IO bus.

## Interface
- NSRC, 4: number of sources, 1..31; source ids run 1..NSRC.
- EDGE, {NSRC{1'b0}}: per-source trigger type; bit i = 1 means source i+1 is rising-edge, 0 means level-high.

- CLK  in  1  system clock; all logic is on the rising edge.
- RESETN  in  1  synchronous, active-low reset, sampled on CLK.
- src  in  NSRC  interrupt request lines; already synchronous to CLK.
- sel  in  1  register window selected this cycle.
- wr  in  1  write strobe; qualified by sel.
- rd  in  1  read strobe; qualified by sel. wr and rd are never both high.
- addr  in  2  word offset: 0 PENDING, 1 ENABLE, 2 CLAIM, 3 COMPLETE.
- wdata  in  32  write data.
- rdata  out  32  read data; registered.
- irq_out  out  1  interrupt request to the core; registered.

## Operation
- Each source runs a gateway FSM with states IDLE, PEND and CLAIMED; reset state is IDLE.
- IDLE -> PEND: on a level source while src is high; on an edge source on a rising edge (src high, previous-cycle src low).
- PEND -> CLAIMED: when a CLAIM read selects this source.
- PEND -> IDLE: only by a PENDING W1C write, and only for edge sources. Level sources ignore W1C.
- CLAIMED -> IDLE: when a COMPLETE write matches this id (wdata[4:0]).
  - Level source still high: it re-enters PEND on the following cycle.
  - Edge source: a rising edge seen while CLAIMED sets a one-bit "again" flag. On complete the source goes to PEND instead of IDLE, and the flag clears.
  - Edges seen in PEND merge into the existing request and are not counted.
- PENDING read: bit i = 1 if source i+1 is in PEND; bits above NSRC read 0.
- ENABLE read/write: NSRC bits, reset 0. Writes replace all bits; upper bits are ignored and read 0.
- CLAIM read returns the lowest-numbered id that is in PEND with its enable bit set, and moves that source to CLAIMED.
  - If no source qualifies, it returns 0 and state is unchanged.
  - Writes to CLAIM are ignored.
- COMPLETE write: an id of 0, an id above NSRC, or an id not in CLAIMED is ignored. COMPLETE reads 0.
- irq_out = OR over sources of (PEND and enabled). Claimed sources do not contribute.
- Disabling an enabled source does not change its FSM state; it only masks it from irq_out and from CLAIM.
- Simultaneous events:
  - Edge and W1C in the same cycle on the same source: the set wins and the source stays PEND.
  - CLAIM read and a new request on another source in the same cycle: the claim uses the pre-edge state, and the new source becomes PEND.
  - COMPLETE write and a rising edge on the same edge source: the source goes to PEND.
- Reset: all FSMs go to IDLE, "again" flags and edge history clear, ENABLE = 0, rdata = 0, irq_out = 0. Reset in any state, including mid-claim, discards all requests.

## Timing
- src sampled high at edge n: PEND visible in the PENDING read value from edge n+1; irq_out high after edge n+2 (one registered stage).
- Read: sel&rd at edge n; rdata is valid after edge n and holds until the next read. The CLAIM state change also commits at edge n.
- irq_out falls on the edge after the claiming read.
- Write: takes effect at the sampling edge; the read-back value reflects the write from the next cycle.
- No wait states; the block accepts one access per cycle, back-to-back.

## Structure
- Shared package `irq_pkg`:
  - register offsets REG_PENDING, REG_ENABLE, REG_CLAIM, REG_COMPLETE;
  - gateway state encoding GW_IDLE, GW_PEND, GW_CLAIMED;
  - the ID_W = 5 constant.
- Sub-module `irq_gateway`: the per-source FSM, edge detect and "again" flag, instantiated NSRC times in a generate loop.
- Top level `irq_ctrl`: ENABLE register, priority encoder, bus decode, rdata and irq_out registers.

## Test plan
- Level source 1 held high, ENABLE=1: irq_out rises 2 cycles later; CLAIM read returns 1 and irq_out drops; COMPLETE 1 with src still high: PENDING=1 again the next cycle.
- Sources 2 and 3 pending, both enabled: CLAIM returns 2, then 3, then 0; a second COMPLETE 2 is ignored.
- Edge source (EDGE=4'b0010), pulse src[1] while CLAIMED, then COMPLETE 2: source returns to PEND and the next CLAIM returns 2. Three pulses while PEND yield only one claim.
- ENABLE=0 with source 1 pending: irq_out stays 0, CLAIM returns 0, PENDING reads 1; ENABLE=1 then raises irq_out on the next cycle.
- W1C and a rising edge in the same cycle on an edge source: PENDING bit stays 1. W1C on a level source has no effect.
- Assert RESETN=0 for one cycle while a source is CLAIMED: afterwards PENDING=0, ENABLE=0, irq_out=0, and a later CLAIM returns 0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt receiver: register map, gateway
// state encoding and the fixed-priority id encoder.
package irq_pkg;

    localparam int ID_W = 5;

    localparam logic [1:0] REG_PENDING  = 2'd0;
    localparam logic [1:0] REG_ENABLE   = 2'd1;
    localparam logic [1:0] REG_CLAIM    = 2'd2;
    localparam logic [1:0] REG_COMPLETE = 2'd3;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PEND    = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_t;

    // Lowest set bit wins; bit i maps to id i+1, and 0 means nothing qualifies.
    function automatic logic [ID_W-1:0] lowest_id(input logic [30:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 30; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i + 1);
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source request gateway: input register, edge detect, IDLE/PEND/CLAIMED
// FSM and the one-bit "again" flag for edges that arrive while claimed.
module irq_gateway
    import irq_pkg::*;
#(
    parameter bit IS_EDGE = 1'b0
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic i_src,
    input  logic i_claim,
    input  logic i_complete,
    input  logic i_w1c,
    output logic o_pend
);

    gw_state_t r_state;
    logic      r_src;
    logic      r_src_d;
    logic      r_again;

    logic      w_rise;
    logic      w_req;

    assign w_rise = r_src & ~r_src_d;
    assign w_req  = IS_EDGE ? w_rise : r_src;
    assign o_pend = (r_state == GW_PEND);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state <= GW_IDLE;
            r_src   <= 1'b0;
            r_src_d <= 1'b0;
            r_again <= 1'b0;
        end else begin
            r_src   <= i_src;
            r_src_d <= r_src;
            case (r_state)
                GW_IDLE: begin
                    if (w_req) r_state <= GW_PEND;
                end
                GW_PEND: begin
                    // A new edge landing with the W1C keeps the request alive.
                    if (i_claim)
                        r_state <= GW_CLAIMED;
                    else if (IS_EDGE && i_w1c && !w_rise)
                        r_state <= GW_IDLE;
                end
                GW_CLAIMED: begin
                    if (i_complete) begin
                        r_again <= 1'b0;
                        r_state <= (IS_EDGE && (r_again || w_rise)) ? GW_PEND : GW_IDLE;
                    end else if (IS_EDGE && w_rise) begin
                        r_again <= 1'b1;
                    end
                end
                default: r_state <= GW_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt receiver top: ENABLE register, fixed-priority claim encoder,
// register window decode and the registered rdata / irq_out outputs.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int               NSRC = 4,
    parameter logic [NSRC-1:0]  EDGE = {NSRC{1'b0}}
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic [NSRC-1:0] src,
    input  logic            sel,
    input  logic            wr,
    input  logic            rd,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq_out
);

    logic [NSRC-1:0] r_en;
    logic [31:0]     r_rdata;
    logic            r_irq;

    logic [NSRC-1:0] w_pend;
    logic [NSRC-1:0] w_elig;
    logic [30:0]     w_elig_ext;
    logic [31:0]     w_pend_ext;
    logic [31:0]     w_en_ext;
    logic [ID_W-1:0] w_claim_id;
    logic            w_rd;
    logic            w_wr;
    logic            w_claim_rd;
    logic            w_cmpl_wr;
    logic            w_w1c_wr;
    logic            w_unused;

    assign w_rd       = sel & rd;
    assign w_wr       = sel & wr;
    assign w_claim_rd = w_rd & (addr == REG_CLAIM);
    assign w_cmpl_wr  = w_wr & (addr == REG_COMPLETE);
    assign w_w1c_wr   = w_wr & (addr == REG_PENDING);
    assign w_elig     = w_pend & r_en;
    assign w_unused   = ^wdata;

    always_comb begin
        w_elig_ext = '0;
        w_pend_ext = '0;
        w_en_ext   = '0;
        w_elig_ext[NSRC-1:0] = w_elig;
        w_pend_ext[NSRC-1:0] = w_pend;
        w_en_ext[NSRC-1:0]   = r_en;
    end

    assign w_claim_id = lowest_id(w_elig_ext);

    // Claim and complete strobes are steered by id; a gateway not in the
    // matching state ignores them.
    for (genvar g = 0; g < NSRC; g++) begin : g_gw
        irq_gateway #(
            .IS_EDGE (EDGE[g])
        ) u_gw (
            .CLK        (CLK),
            .RESETN     (RESETN),
            .i_src      (src[g]),
            .i_claim    (w_claim_rd && (w_claim_id == ID_W'(g + 1))),
            .i_complete (w_cmpl_wr && (wdata[ID_W-1:0] == ID_W'(g + 1))),
            .i_w1c      (w_w1c_wr && wdata[g]),
            .o_pend     (w_pend[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_en    <= '0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= |w_elig;
            if (w_wr && (addr == REG_ENABLE)) r_en <= wdata[NSRC-1:0];
            if (w_rd) begin
                case (addr)
                    REG_PENDING: r_rdata <= w_pend_ext;
                    REG_ENABLE:  r_rdata <= w_en_ext;
                    REG_CLAIM:   r_rdata <= {{(32-ID_W){1'b0}}, w_claim_id};
                    default:     r_rdata <= '0;
                endcase
            end
        end
    end

    assign rdata   = r_rdata;
    assign irq_out = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: per-cycle comparison against a request/claim model
// plus directed register reads with hand-computed expectations.
module tb_irq_ctrl;

    localparam int              NSRC    = 4;
    localparam logic [NSRC-1:0] TB_EDGE = 4'b0010;

    logic            CLK;
    logic            RESETN;
    logic [NSRC-1:0] src;
    logic            sel, wr, rd;
    logic [1:0]      addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            irq_out;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    irq_ctrl #(.NSRC(NSRC), .EDGE(TB_EDGE)) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .src     (src),
        .sel     (sel),
        .wr      (wr),
        .rd      (rd),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq_out (irq_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    // Model: a request is seen one edge after src is sampled; pending
    // requests are claimed lowest-id-first among enabled ones.
    logic [NSRC-1:0] m_pend, m_clm, m_again, m_s1, m_s2, m_en;
    logic [31:0]     m_rdata;
    logic            m_irq;

    always @(posedge CLK) begin : model
        logic [NSRC-1:0] np, nc, na, elig;
        logic [31:0]     nr;
        int              cid;
        bit              rise, req, rdo, wro, cmp;
        if (!RESETN) begin
            m_pend <= '0; m_clm <= '0; m_again <= '0;
            m_s1 <= '0; m_s2 <= '0; m_en <= '0;
            m_rdata <= '0; m_irq <= 1'b0;
        end else begin
            np = m_pend; nc = m_clm; na = m_again; nr = m_rdata;
            elig = m_pend & m_en;
            cid = 0;
            for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) cid = i + 1;
            rdo = sel && rd;
            wro = sel && wr;
            if (rdo) begin
                case (addr)
                    2'd0:    nr = 32'(m_pend);
                    2'd1:    nr = 32'(m_en);
                    2'd2:    nr = 32'(cid);
                    default: nr = '0;
                endcase
            end
            for (int i = 0; i < NSRC; i++) begin
                rise = m_s1[i] && !m_s2[i];
                req  = TB_EDGE[i] ? rise : m_s1[i];
                cmp  = wro && (addr == 2'd3) && (wdata[4:0] == 5'(i + 1));
                if (m_pend[i]) begin
                    if (rdo && (addr == 2'd2) && (cid == i + 1)) begin
                        np[i] = 1'b0; nc[i] = 1'b1;
                    end else if (TB_EDGE[i] && wro && (addr == 2'd0) && wdata[i] && !rise) begin
                        np[i] = 1'b0;
                    end
                end else if (m_clm[i]) begin
                    if (cmp) begin
                        nc[i] = 1'b0;
                        np[i] = TB_EDGE[i] && (m_again[i] || rise);
                        na[i] = 1'b0;
                    end else if (TB_EDGE[i] && rise) begin
                        na[i] = 1'b1;
                    end
                end else if (req) begin
                    np[i] = 1'b1;
                end
            end
            m_pend  <= np;
            m_clm   <= nc;
            m_again <= na;
            m_rdata <= nr;
            m_irq   <= |elig;
            if (wro && (addr == 2'd1)) m_en <= wdata[NSRC-1:0];
            m_s2 <= m_s1;
            m_s1 <= src;
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            check("cyc_rdata", rdata, m_rdata);
            check("cyc_irq", {31'd0, irq_out}, {31'd0, m_irq});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge CLK);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge CLK);
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        @(negedge CLK);
        sel = 1'b1; rd = 1'b1; addr = a;
        @(negedge CLK);
        sel = 1'b0; rd = 1'b0;
        check(name, rdata, exp);
    endtask

    task automatic pulse(input int s);
        @(negedge CLK);
        src[s] = 1'b1;
        @(negedge CLK);
        src[s] = 1'b0;
    endtask

    initial begin
        RESETN = 1'b0; src = '0; sel = 1'b0; wr = 1'b0; rd = 1'b0;
        addr = 2'd0; wdata = '0;
        @(posedge CLK);
        chk_on = 1'b1;
        cyc(2);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", {31'd0, irq_out}, 32'd0);
        RESETN = 1'b1;
        bus_rd(2'd0, 32'd0, "rst_pending");
        bus_rd(2'd1, 32'd0, "rst_enable");

        // Level source 1: irq latency, claim, complete with src still high
        bus_wr(2'd1, 32'h0000_0001);
        src[0] = 1'b1;
        cyc(2);
        check("lvl_irq_early", {31'd0, irq_out}, 32'd0);
        cyc(1);
        check("lvl_irq_rise", {31'd0, irq_out}, 32'd1);
        bus_rd(2'd2, 32'd1, "lvl_claim1");
        cyc(1);
        check("lvl_irq_drop", {31'd0, irq_out}, 32'd0);
        bus_wr(2'd3, 32'd1);
        cyc(1);
        bus_rd(2'd0, 32'h1, "lvl_repend");
        src[0] = 1'b0;
        cyc(2);
        bus_rd(2'd2, 32'd1, "lvl_claim1b");
        bus_wr(2'd3, 32'd1);

        // Sources 2 (edge) and 3 (level): priority order, empty claim
        bus_wr(2'd1, 32'h0000_0006);
        @(negedge CLK); src[1] = 1'b1; src[2] = 1'b1;
        @(negedge CLK); src[1] = 1'b0;
        cyc(3);
        bus_rd(2'd1, 32'h6, "enable_rb");
        bus_rd(2'd2, 32'd2, "prio_claim2");
        bus_rd(2'd2, 32'd3, "prio_claim3");
        bus_rd(2'd2, 32'd0, "prio_claim0");
        bus_wr(2'd3, 32'd2);
        bus_wr(2'd3, 32'd2);
        bus_rd(2'd0, 32'h0, "prio_pending");
        bus_rd(2'd3, 32'h0, "complete_rd");
        src[2] = 1'b0;
        cyc(2);
        bus_wr(2'd3, 32'd3);
        bus_wr(2'd3, 32'd0);
        bus_wr(2'd3, 32'd9);

        // Edge source 2: edge while claimed, then merged edges while pending
        pulse(1);
        cyc(3);
        bus_rd(2'd0, 32'h2, "edge_pend");
        bus_rd(2'd2, 32'd2, "edge_claim");
        pulse(1);
        cyc(2);
        bus_wr(2'd3, 32'd2);
        bus_rd(2'd0, 32'h2, "edge_again_pend");
        bus_rd(2'd2, 32'd2, "edge_again_claim");
        bus_wr(2'd3, 32'd2);
        pulse(1); pulse(1); pulse(1);
        cyc(3);
        bus_rd(2'd2, 32'd2, "merge_claim");
        bus_wr(2'd3, 32'd2);
        bus_rd(2'd2, 32'd0, "merge_claim0");

        // Masked pending source
        bus_wr(2'd1, 32'h0);
        src[0] = 1'b1;
        cyc(3);
        check("mask_irq", {31'd0, irq_out}, 32'd0);
        bus_rd(2'd2, 32'd0, "mask_claim");
        bus_rd(2'd0, 32'h1, "mask_pending");
        bus_wr(2'd1, 32'hFFFF_FFF1);
        check("unmask_irq0", {31'd0, irq_out}, 32'd0);
        cyc(1);
        check("unmask_irq1", {31'd0, irq_out}, 32'd1);
        bus_rd(2'd1, 32'h1, "enable_upper");
        src[0] = 1'b0;
        cyc(2);
        bus_rd(2'd2, 32'd1, "mask_claim1");
        bus_wr(2'd3, 32'd1);

        // W1C racing a rising edge, plain W1C, W1C on a level source
        pulse(1);
        cyc(3);
        bus_rd(2'd0, 32'h2, "w1c_pre");
        @(negedge CLK); src[1] = 1'b1;
        @(negedge CLK); src[1] = 1'b0;
        sel = 1'b1; wr = 1'b1; addr = 2'd0; wdata = 32'h2;
        @(negedge CLK); sel = 1'b0; wr = 1'b0;
        bus_rd(2'd0, 32'h2, "w1c_race");
        bus_wr(2'd0, 32'h2);
        bus_rd(2'd0, 32'h0, "w1c_clear");
        src[2] = 1'b1;
        cyc(3);
        bus_wr(2'd0, 32'h4);
        bus_rd(2'd0, 32'h4, "w1c_level");

        // Reset while source 3 is claimed
        bus_wr(2'd1, 32'h4);
        bus_rd(2'd2, 32'd3, "pre_rst_claim");
        src[2] = 1'b0;
        cyc(2);
        @(negedge CLK); RESETN = 1'b0;
        @(negedge CLK); RESETN = 1'b1;
        check("post_rst_irq", {31'd0, irq_out}, 32'd0);
        bus_rd(2'd0, 32'h0, "post_rst_pending");
        bus_rd(2'd1, 32'h0, "post_rst_enable");
        bus_rd(2'd2, 32'd0, "post_rst_claim");
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
